muldiv_ctrl: RTL and testbench

Sequencer and owner of the HI/LO register pair for the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations and runs multiplies as a two-cycle registered operation. Divides are run on the external multi-cycle `div` unit through its start/annul/ready handshake. It stalls the pipeline until the HI/LO result is committed and cancels in-flight work on an exception flush.

---
 rtl/muldiv_ctrl.sv | 163 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage sequencer owning the HI/LO register pair.
// Multiplies run as a two-cycle registered operation. Divides are handed to an
// external multi-cycle divider through a start/annul/ready handshake.
// Optional feature macro: MULDIV_DIV0_SKIP_EN. When it is defined, a divide by zero
// skips the divider and commits hi=a, lo=all-ones after a single stall cycle.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL      = 2'd1,
        ST_DIV_RUN  = 2'd2,
        ST_DIV_DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state_reg, state_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] mul_a_reg, mul_a_next;
    logic [31:0] mul_b_reg, mul_b_next;
    logic        mul_signed_reg, mul_signed_next;
    logic [31:0] opd1_reg, opd1_next;
    logic [31:0] opd2_reg, opd2_next;
    logic        div_signed_reg, div_signed_next;

    // Both operands extended to 64 bits (sign or zero), so the low 64 bits of
    // the 64x64 product are exactly the 32x32 result.
    logic signed [63:0] mul_a_ext, mul_b_ext, mul_prod;
    assign mul_a_ext = {{32{mul_signed_reg & mul_a_reg[31]}}, mul_a_reg};
    assign mul_b_ext = {{32{mul_signed_reg & mul_b_reg[31]}}, mul_b_reg};
    assign mul_prod  = mul_a_ext * mul_b_ext;

    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign div_signed  = div_signed_reg;
    assign div_opdata1 = opd1_reg;
    assign div_opdata2 = opd2_reg;
    // Start follows the state register (so reset drops it at once) and is
    // gated off in the cycle the divider reports ready or a flush arrives.
    assign div_start   = (state_reg == ST_DIV_RUN) & ~div_ready & ~flush;

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            hi_reg         <= '0;
            lo_reg         <= '0;
            mul_a_reg      <= '0;
            mul_b_reg      <= '0;
            mul_signed_reg <= 1'b0;
            opd1_reg       <= '0;
            opd2_reg       <= '0;
            div_signed_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hi_reg         <= hi_next;
            lo_reg         <= lo_next;
            mul_a_reg      <= mul_a_next;
            mul_b_reg      <= mul_b_next;
            mul_signed_reg <= mul_signed_next;
            opd1_reg       <= opd1_next;
            opd2_reg       <= opd2_next;
            div_signed_reg <= div_signed_next;
        end
    end

    // Next-state, HI/LO update and stall/annul decode; flush overrides everything.
    always_comb begin
        state_next      = state_reg;
        hi_next         = hi_reg;
        lo_next         = lo_reg;
        mul_a_next      = mul_a_reg;
        mul_b_next      = mul_b_reg;
        mul_signed_next = mul_signed_reg;
        opd1_next       = opd1_reg;
        opd2_next       = opd2_reg;
        div_signed_next = div_signed_reg;
        stall           = 1'b0;
        div_annul       = 1'b0;

        if (flush) begin
            state_next = ST_IDLE;
            div_annul  = (state_reg == ST_DIV_RUN);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                mul_a_next      = a;
                                mul_b_next      = b;
                                mul_signed_next = (op == OP_MULT);
                                stall           = 1'b1;
                                state_next      = ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                opd1_next       = a;
                                opd2_next       = b;
                                div_signed_next = (op == OP_DIV);
                                stall           = 1'b1;
`ifdef MULDIV_DIV0_SKIP_EN
                                if (b == 32'd0) begin
                                    hi_next    = a;
                                    lo_next    = 32'hFFFF_FFFF;
                                    state_next = ST_DIV_DONE;
                                end else begin
                                    state_next = ST_DIV_RUN;
                                end
`else
                                state_next      = ST_DIV_RUN;
`endif
                            end
                            OP_MTHI: hi_next = a;
                            OP_MTLO: lo_next = a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    // op_valid is the same held instruction; ignore it.
                    hi_next    = mul_prod[63:32];
                    lo_next    = mul_prod[31:0];
                    state_next = ST_IDLE;
                end
                ST_DIV_RUN: begin
                    stall = 1'b1;
                    if (div_ready) begin
                        hi_next    = div_result[63:32];
                        lo_next    = div_result[31:0];
                        state_next = ST_DIV_DONE;
                    end
                end
                ST_DIV_DONE: state_next = ST_IDLE;
                default:     state_next = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl. Inputs change on the falling edge; the
// combinational outputs are checked 1ns later and the registered outputs 1ns
// after the rising edge. The bench plays the divider itself, producing results
// from plain integer arithmetic.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] hi, lo;
    logic        div_start, div_signed, div_annul;
    logic [31:0] div_opdata1, div_opdata2;
    logic [63:0] div_result = '0;
    logic        div_ready = 1'b0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .a(a), .b(b),
        .flush(flush), .stall(stall), .hi(hi), .lo(lo),
        .div_start(div_start), .div_signed(div_signed),
        .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_annul(div_annul), .div_result(div_result), .div_ready(div_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference divider: {remainder, quotient}; divide by zero yields {a, all-ones}.
    function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        sx = sgn ? longint'($signed(x)) : longint'({32'd0, x});
        sy = sgn ? longint'($signed(y)) : longint'({32'd0, y});
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [63:0] mul_ref(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        longint p;
        if (sgn) p = longint'($signed(x)) * longint'($signed(y));
        else     p = longint'({32'd0, x}) * longint'({32'd0, y});
        return p;
    endfunction

    task automatic chk_hilo(input string tag);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    task automatic run_mul(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = mul_ref(sgn, x, y);
        @(negedge clk);
        op_valid = 1'b1; op = sgn ? 3'd0 : 3'd1; a = x; b = y; flush = 1'b0;
        #1;
        chk("mul_stall_c1", stall, 1);
        chk("mul_start_c1", div_start, 0);
        @(negedge clk);
        #1;
        chk("mul_stall_c2", stall, 0);
        chk_hilo("mul_pre");
        @(posedge clk); #1;
        exp_hi = p[63:32]; exp_lo = p[31:0];
        chk_hilo("mul_post");
        $display("txn %s a=%h b=%h -> hi=%h lo=%h", sgn ? "MULT " : "MULTU", x, y, hi, lo);
    endtask

    // lat: DIV_RUN cycles until ready (>=1); fl_at: DIV_RUN cycle carrying flush (0 = none).
    task automatic run_div(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                           input int lat, input int fl_at);
        logic [63:0] res;
        int          n_stall;
        logic        aborted;
        res = div_ref(sgn, x, y);
        n_stall = 0;
        aborted = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; op = sgn ? 3'd2 : 3'd3; a = x; b = y; flush = 1'b0;
        #1;
        chk("div_stall_c0", stall, 1);
        chk("div_start_c0", div_start, 0);
        n_stall += int'(stall);
        @(posedge clk); #1;
`ifdef MULDIV_DIV0_SKIP_EN
        if (y == 32'd0) begin
            exp_hi = x; exp_lo = 32'hFFFF_FFFF;
            chk_hilo("div0_post");
            @(negedge clk); #1;
            chk("div0_done_stall", stall, 0);
            chk("div0_done_start", div_start, 0);
            @(posedge clk); #1;
            $display("txn DIV0-skip a=%h -> hi=%h lo=%h", x, hi, lo);
            return;
        end
`endif
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            div_ready  = (k == lat);
            div_result = (k == lat) ? res : {$urandom, $urandom};
            flush      = (k == fl_at);
            #1;
            chk("div_run_stall", stall, (k == fl_at) ? 0 : 1);
            chk("div_run_start", div_start, (k == lat || k == fl_at) ? 0 : 1);
            chk("div_run_annul", div_annul, (k == fl_at) ? 1 : 0);
            chk("div_opdata1", div_opdata1, x);
            chk("div_opdata2", div_opdata2, y);
            chk("div_signed", div_signed, sgn);
            chk_hilo("div_run_hold");
            n_stall += int'(stall);
            @(posedge clk); #1;
            if (k == fl_at) begin
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            chk_hilo("div_flush_keep");
            @(negedge clk);
            op_valid = 1'b0; flush = 1'b0; div_ready = 1'b0;
            #1;
            chk("div_flush_idle_stall", stall, 0);
            chk("div_flush_idle_start", div_start, 0);
            @(posedge clk); #1;
            $display("txn %s a=%h b=%h flushed at run cycle %0d", sgn ? "DIV " : "DIVU", x, y, fl_at);
            return;
        end
        exp_hi = res[63:32]; exp_lo = res[31:0];
        chk_hilo("div_post");
        chk("div_stall_count", n_stall, 1 + lat);
        @(negedge clk);
        div_ready = 1'b0;
        #1;
        chk("div_done_stall", stall, 0);
        chk("div_done_start", div_start, 0);
        @(posedge clk); #1;
        $display("txn %s a=%h b=%h lat=%0d -> hi=%h lo=%h", sgn ? "DIV " : "DIVU", x, y, lat, hi, lo);
    endtask

    // MTHI/MTLO (op 4/5) or a no-op code (6/7), optionally with flush.
    task automatic run_mt(input logic [2:0] o, input logic [31:0] x, input logic fl);
        @(negedge clk);
        op_valid = 1'b1; op = o; a = x; b = $urandom; flush = fl;
        #1;
        chk("mt_stall", stall, 0);
        chk_hilo("mt_pre");
        @(posedge clk); #1;
        if (!fl && o == 3'd4) exp_hi = x;
        if (!fl && o == 3'd5) exp_lo = x;
        chk_hilo("mt_post");
        $display("txn op%0d a=%h flush=%0d -> hi=%h lo=%h", o, x, fl, hi, lo);
    endtask

    initial begin
        // Reset state while rst is held low.
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_start", div_start, 0);
        chk("rst_annul", div_annul, 0);
        chk("rst_signed", div_signed, 0);
        chk("rst_opd1", div_opdata1, 0);
        chk("rst_opd2", div_opdata2, 0);
        chk_hilo("rst");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_hilo("idle");
        chk("idle_stall", stall, 0);

        run_mul(1'b1, 32'hFFFF_FFFE, 32'd3);
        run_mul(1'b0, 32'hFFFF_FFFE, 32'd3);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 34, 0);
        run_div(1'b0, 32'd1000, 32'd7, 20, 10);
        run_div(1'b0, 32'hDEAD_BEEF, 32'd16, 5, 0);
        run_mt(3'd4, 32'h1234_5678, 1'b0);
        run_mt(3'd5, 32'h9ABC_DEF0, 1'b0);
        run_mt(3'd5, 32'h5555_AAAA, 1'b1);
        run_mt(3'd6, 32'hCAFE_F00D, 1'b0);
        run_div(1'b1, 32'd5, 32'd0, 3, 0);

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            int          kind, lat;
            logic [31:0] x, y;
            kind = $urandom_range(0, 3);
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            case (kind)
                0: run_mul(1'($urandom_range(0, 1)), x, y);
                1: begin
                    lat = $urandom_range(1, 8);
                    run_div(1'($urandom_range(0, 1)), x, y, lat,
                            (lat > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, lat - 1) : 0);
                end
                2: run_mt(3'($urandom_range(4, 7)), x, 1'($urandom_range(0, 4) == 0));
                default: begin
                    @(negedge clk);
                    op_valid = 1'b0; flush = 1'b0;
                    @(posedge clk); #1;
                    chk_hilo("idle_rand");
                    $display("txn idle -> hi=%h lo=%h", hi, lo);
                end
            endcase
        end

        // Reset asserted mid-divide aborts at once.
        @(negedge clk);
        op_valid = 1'b1; op = 3'd3; a = 32'd99; b = 32'd4; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_rst_start_before", div_start, 1);
        #2;
        rst = 1'b0; op_valid = 1'b0;
        #1;
        chk("mid_rst_start", div_start, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_opd1", div_opdata1, 0);
        exp_hi = '0; exp_lo = '0;
        chk_hilo("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        $display("txn reset during DIVU -> hi=%h lo=%h", hi, lo);
        run_div(1'b0, 32'd100, 32'd9, 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
